// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - debounced key sampler, round-robin event arbiter and event FIFO
// Optional auto-repeat is built when KEY_REPEAT_EN is defined.
module key_event_ctrl #(
    parameter int NKEYS    = 8,
    parameter int TICK_MAX = 29999,
    parameter int DEPTH    = 4,
    parameter int RPT_DLY  = 200,
    parameter int RPT_PER  = 40,
    localparam int CW      = $clog2(NKEYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] keys,
    output logic             evt_valid,
    output logic [CW-1:0]    evt_code,
    output logic             evt_rpt,
    input  logic             evt_ready,
    output logic             ovf,
    input  logic             ovf_clr
);
    localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int AW = $clog2(DEPTH);

    if (NKEYS < 2 || NKEYS > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_params
        $error("key_event_ctrl: parameter out of range");
    end

    logic [TW-1:0]    r_tick_cnt;
    logic [NKEYS-1:0] r_sync1, r_sync2, r_prev, r_pending;
    logic [CW-1:0]    r_rr_ptr;
    logic [CW-1:0]    r_mem_code [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;

    logic             w_tick, w_full, w_empty, w_pop, w_push, w_found, w_push_key, w_push_rpt;
    logic [NKEYS-1:0] w_press, w_grant_vec;
    logic [CW-1:0]    w_gidx, w_rpt_code, w_push_code;

    assign w_tick  = (r_tick_cnt == TW'(TICK_MAX));
    assign w_press = w_tick ? (r_sync2 & ~r_prev) : '0;
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && evt_ready;

    // First pending bit at or after the round-robin pointer, wrapping.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NKEYS; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NKEYS) j = j - NKEYS;
            if (!w_found && r_pending[j[CW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = j[CW-1:0];
            end
        end
    end

    assign w_push_key  = w_found && !w_full;
    assign w_grant_vec = NKEYS'(w_push_key) << w_gidx;
    assign w_push      = w_push_key || w_push_rpt;
    assign w_push_code = w_push_key ? w_gidx : w_rpt_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_pending  <= '0;
            r_rr_ptr   <= '0;
            r_ovf      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_sync1    <= keys;
            r_sync2    <= r_sync1;
            if (w_tick) r_prev <= r_sync2;
            // A press on the bit being granted this clk re-sets it without loss.
            r_pending <= (r_pending & ~w_grant_vec) | w_press;
            if (|(w_press & r_pending & ~w_grant_vec)) r_ovf <= 1'b1;
            else if (ovf_clr)                          r_ovf <= 1'b0;
            if (w_push_key)
                r_rr_ptr <= (w_gidx == CW'(NKEYS - 1)) ? '0 : w_gidx + CW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem_code[r_wr_ptr] <= w_push_code;
    end

    assign evt_valid = !w_empty;
    assign evt_code  = w_empty ? '0 : r_mem_code[r_rd_ptr];
    assign ovf       = r_ovf;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    logic          r_mem_rpt [DEPTH];
    logic [CW-1:0] r_last_idx;
    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_first, r_rpt_act, r_rpt_req;
    logic [CW-1:0] w_low_idx;
    logic [RW-1:0] w_rpt_next, w_rpt_term;

    always_comb begin
        w_low_idx = '0;
        for (int k = NKEYS - 1; k >= 0; k--)
            if (w_press[k[CW-1:0]]) w_low_idx = k[CW-1:0];
    end

    assign w_rpt_next = r_rpt_cnt + RW'(1);
    assign w_rpt_term = r_rpt_first ? RW'(RPT_DLY) : RW'(RPT_PER);
    // Repeat request sits below every pending key and is discarded when the FIFO is full.
    assign w_push_rpt = !w_found && r_rpt_req && !w_full;
    assign w_rpt_code = r_last_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_idx  <= '0;
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
            r_rpt_act   <= 1'b0;
            r_rpt_req   <= 1'b0;
        end else begin
            if (w_push_rpt || (r_rpt_req && w_full)) r_rpt_req <= 1'b0;
            if (w_tick) begin
                if (|w_press) begin
                    r_last_idx  <= w_low_idx;
                    r_rpt_cnt   <= '0;
                    r_rpt_first <= 1'b1;
                    r_rpt_act   <= 1'b1;
                end else if (r_rpt_act && r_sync2[r_last_idx]) begin
                    if (w_rpt_next == w_rpt_term) begin
                        r_rpt_req   <= 1'b1;
                        r_rpt_cnt   <= '0;
                        r_rpt_first <= 1'b0;
                    end else begin
                        r_rpt_cnt <= w_rpt_next;
                    end
                end else begin
                    r_rpt_act <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem_rpt[r_wr_ptr] <= w_push_rpt;
    end

    assign evt_rpt = !w_empty && r_mem_rpt[r_rd_ptr];
`else
    assign w_push_rpt = 1'b0;
    assign w_rpt_code = '0;
    assign evt_rpt    = 1'b0;
`endif
endmodule
